// File: rtl/pt5_cfg_loader_pkg.sv
// Shared definitions for the PT5 configuration loader: FSM encodings, config bit
// positions inside each macrocell slice, and the default sync word.
package pt5_cfg_loader_pkg;

  localparam int unsigned SYNC_BITS        = 8;
  localparam int unsigned PT5_MUX_BIT      = 0;
  localparam int unsigned PT5_FUNC_BIT     = 1;
  localparam logic [7:0]  DEFAULT_PREAMBLE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_PARITY = 3'd3,
    ST_COMMIT = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } cfg_state_e;

endpackage

// File: rtl/pt5_cfg_loader_cfg_shadow_sr.sv
// Payload shadow shift register with running even-parity accumulator.
// New bits enter at the top and move toward index 0.
module pt5_cfg_loader_cfg_shadow_sr #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         sdi,
  output logic [W-1:0] shadow,
  output logic         parity
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      parity <= 1'b0;
    end else if (clr) begin
      shadow <= '0;
      parity <= 1'b0;
    end else if (shift_en) begin
      shadow <= {sdi, shadow[W-1:1]};
      parity <= parity ^ sdi;
    end
  end

endmodule

// File: rtl/pt5_cfg_loader.sv
// Serial fuse-configuration loader: verifies preamble, payload and parity of a
// frame before committing it to the PT5 mux/func-mux select image.
module pt5_cfg_loader
  import pt5_cfg_loader_pkg::*;
#(
  parameter int unsigned NUM_MC   = 16,
  parameter int unsigned CFG_BITS = 2,
  parameter logic [7:0]  PREAMBLE = DEFAULT_PREAMBLE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       sen,
  input  logic                       sdi,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       cfg_valid,
  output logic [NUM_MC*CFG_BITS-1:0] cfg_word,
  output logic [NUM_MC-1:0]          pt5_mux,
  output logic [NUM_MC-1:0]          pt5_func_mux
);

  localparam int unsigned N     = NUM_MC * CFG_BITS;
  localparam int unsigned CNT_W = $clog2(N + 1);

  cfg_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         sync_q, sync_d;
  logic [N-1:0]       cfg_q, cfg_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sr_clr, sr_shift;
  logic [N-1:0]       shadow;
  logic               parity;

  pt5_cfg_loader_cfg_shadow_sr #(.W(N)) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .clr      (sr_clr),
    .shift_en (sr_shift),
    .sdi      (sdi),
    .shadow   (shadow),
    .parity   (parity)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sync_q  <= '0;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; abort outranks sen in the loading states, COMMIT runs to completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sync_d   = sync_q;
    cfg_d    = cfg_q;
    valid_d  = valid_q;
    err_d    = err_q;
    sr_clr   = 1'b0;
    sr_shift = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SYNC;
          err_d   = 1'b0;
          cnt_d   = '0;
          sync_d  = '0;
          sr_clr  = 1'b1;
        end
      end
      ST_SYNC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (sen) begin
          sync_d = {sync_q[6:0], sdi};
          if (cnt_q == CNT_W'(SYNC_BITS - 1)) begin
            cnt_d   = '0;
            state_d = (sync_d == PREAMBLE) ? ST_SHIFT : ST_ERR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (sen) begin
          sr_shift = 1'b1;
          if (cnt_q != CNT_W'(N)) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (sen) begin
          state_d = (sdi ^ parity) ? ST_ERR : ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        cfg_d   = shadow;
        valid_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_d == ST_ERR) err_d = 1'b1;

    busy_d = (state_d == ST_SYNC) || (state_d == ST_SHIFT) ||
             (state_d == ST_PARITY) || (state_d == ST_COMMIT);
    done_d = (state_d == ST_DONE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cfg_valid = valid_q;
  assign cfg_word  = cfg_q;

  for (genvar i = 0; i < NUM_MC; i++) begin : g_mc
    assign pt5_mux[i]      = cfg_q[i*CFG_BITS + PT5_MUX_BIT];
    assign pt5_func_mux[i] = cfg_q[i*CFG_BITS + PT5_FUNC_BIT];
  end

endmodule
